dmem_responder: RTL and testbench

//  Responder end of the datapath data-memory port: services loads and stores issued by the

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I datapath: byte-lane RAM, extended loads, sticky fault capture.
// Optional free-running cycle counter at 0xFFFF_FFF0 when DMEM_MMIO_CYCLE_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic        clr_fault,
  output logic [31:0] rd,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      off_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;
  logic             mode_ok_s;
  logic             misalign_s;
  logic             is_mmio_s;
  logic             fault_s;
  logic [31:0]      word_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [3:0]       lane_en_s;
  logic [31:0]      wdata_s;
  logic             wr_en_s;
  logic [31:0]      word_d;
  logic             fault_q;
  logic             fault_d;
  logic [31:0]      fault_addr_q;
  logic [31:0]      fault_addr_d;
`ifdef DMEM_MMIO_CYCLE_EN
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_d;
`endif

  // Address decode and access legality.
  always_comb begin
    off_s      = a - BASE_ADDR;
    idx_s      = off_s[IDX_W+1:2];
    // Compare in 33 bits so the top of the window cannot wrap back to an alias.
    in_range_s = ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, off_s} < SPAN);
    mode_ok_s  = 1'b1;
    misalign_s = 1'b0;
    case (mode)
      3'b000, 3'b100: misalign_s = 1'b0;
      3'b001, 3'b101: misalign_s = a[0];
      3'b010:         misalign_s = (a[1:0] != 2'b00);
      default:        mode_ok_s  = 1'b0;
    endcase
`ifdef DMEM_MMIO_CYCLE_EN
    is_mmio_s = (a == 32'hFFFF_FFF0);
    if (is_mmio_s) begin
      fault_s = (mode != 3'b010);
    end else begin
      fault_s = !mode_ok_s || misalign_s || !in_range_s;
    end
`else
    is_mmio_s = 1'b0;
    fault_s   = !mode_ok_s || misalign_s || !in_range_s;
`endif
  end

  // Load path: lane select and extension, forced to zero on a faulting access.
  always_comb begin
    word_s = mem_q[idx_s];
    case (a[1:0])
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      default: byte_s = word_s[31:24];
    endcase
    half_s = a[1] ? word_s[31:16] : word_s[15:0];
    rd     = 32'h0000_0000;
    if (fault_s) begin
      rd = 32'h0000_0000;
    end else begin
      case (mode)
        3'b000:  rd = {{24{byte_s[7]}}, byte_s};
        3'b100:  rd = {24'h00_0000, byte_s};
        3'b001:  rd = {{16{half_s[15]}}, half_s};
        3'b101:  rd = {16'h0000, half_s};
        3'b010:  rd = word_s;
        default: rd = 32'h0000_0000;
      endcase
`ifdef DMEM_MMIO_CYCLE_EN
      if (is_mmio_s) begin
        rd = cnt_q;
      end else begin
        rd = rd;
      end
`endif
    end
  end

  // Store path: merge the enabled lanes into the currently addressed word.
  always_comb begin
    case (mode[1:0])
      2'b00:   lane_en_s = 4'b0001 << a[1:0];
      2'b01:   lane_en_s = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_en_s = 4'b1111;
      default: lane_en_s = 4'b0000;
    endcase
    case (mode[1:0])
      2'b00:   wdata_s = {4{wd[7:0]}};
      2'b01:   wdata_s = {2{wd[15:0]}};
      default: wdata_s = wd;
    endcase
    wr_en_s = we && !fault_s && !is_mmio_s;
    for (int i = 0; i < 4; i++) begin
      word_d[8*i +: 8] = lane_en_s[i] ? wdata_s[8*i +: 8] : word_s[8*i +: 8];
    end
  end

  // Sticky fault: clear wins, otherwise the first faulting address is kept.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (clr_fault) begin
      fault_d      = 1'b0;
      fault_addr_d = 32'h0000_0000;
    end else if (fault_s) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        fault_addr_d = a;
      end else begin
        fault_addr_d = fault_addr_q;
      end
    end else begin
      fault_d = fault_q;
    end
  end

`ifdef DMEM_MMIO_CYCLE_EN
  // A counter store takes effect and counts in the same edge, so the next read sees wd+1.
  always_comb begin
    if (we && is_mmio_s && !fault_s) begin
      cnt_d = wd + 32'd1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'h0000_0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // RAM array and fault registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0000_0000;
    end else begin
      if (wr_en_s) begin
        mem_q[idx_s] <= word_d;
      end
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array reference model.
// Counter checks are compiled in when DMEM_MMIO_CYCLE_EN is defined.
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [2:0]  mode;
  logic        clr_fault;
  logic [31:0] rd;
  logic        fault;
  logic [31:0] fault_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_mem [DEPTH*4];
  logic        ref_fault;
  logic [31:0] ref_fa;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .mode(mode),
    .clr_fault(clr_fault), .rd(rd), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] md);
    return 1 << md[1:0];
  endfunction

  function automatic bit ref_is_fault(input logic [31:0] ad, input logic [2:0] md);
    longint off;
    if (!(md inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
`ifdef DMEM_MMIO_CYCLE_EN
    if (ad == MMIO) return md != 3'd2;
`endif
    if ((ad % acc_size(md)) != 0) return 1'b1;
    off = longint'(ad) - longint'(BASE);
    if (off < 0 || off >= DEPTH * 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] ad, input logic [2:0] md);
    longint      off;
    int          sz;
    logic [31:0] v;
    if (ref_is_fault(ad, md)) return 32'h0;
    off = longint'(ad) - longint'(BASE);
    sz  = acc_size(md);
    v   = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(off) + i]) << (8 * i));
    if (!md[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    return v;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    ref_fault = 1'b0;
    ref_fa    = 32'h0;
  endtask

  // One access: drive at posedge+1, check mid-cycle, advance model at the edge.
  task automatic access(input string tag, input logic [31:0] ad, input logic [31:0] d,
                        input logic w, input logic [2:0] md, input logic clr,
                        input bit has_lit, input logic [31:0] lit);
    bit  f;
    longint off;
    a = ad; wd = d; we = w; mode = md; clr_fault = clr;
    #3;
    if (ad != MMIO) check({tag, "_rd"}, rd, ref_load(ad, md));
    if (has_lit) check({tag, "_lit"}, rd, lit);
    check({tag, "_fault"}, {31'h0, fault}, {31'h0, ref_fault});
    check({tag, "_faddr"}, fault_addr, ref_fa);
    @(posedge clk);
    f = ref_is_fault(ad, md);
    if (clr) begin
      ref_fault = 1'b0; ref_fa = 32'h0;
    end else if (f) begin
      if (!ref_fault) ref_fa = ad;
      ref_fault = 1'b1;
    end
    if (w && !f && ad != MMIO) begin
      off = longint'(ad) - longint'(BASE);
      for (int i = 0; i < acc_size(md); i++) ref_mem[int'(off) + i] = d[8*i +: 8];
    end
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rm;
    int          pick;
    reset = 1'b0; a = 32'h0; wd = 32'h0; we = 1'b0; mode = 3'd2; clr_fault = 1'b0;
    ref_reset();
    #23;
    reset = 1'b1;
    @(posedge clk); #1;

    access("rst0", 32'h0, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    access("rst4", 32'h4, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    access("rstTop", 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);

    access("sw10", 32'h10, 32'h8899AABB, 1'b1, 3'd2, 1'b0, 1'b0, 32'h0);
    access("sb11", 32'h11, 32'h0000007F, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0);
    access("lw10", 32'h10, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h88997FBB);
    access("lb13", 32'h13, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 32'hFFFFFF88);
    access("lbu13", 32'h13, 32'h0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h00000088);
    access("lh12", 32'h12, 32'h0, 1'b0, 3'd1, 1'b0, 1'b1, 32'hFFFF8899);
    access("lhu12", 32'h12, 32'h0, 1'b0, 3'd5, 1'b0, 1'b1, 32'h00008899);

    access("swmis", 32'h22, 32'hDEADBEEF, 1'b1, 3'd2, 1'b0, 1'b1, 32'h0);
    access("lw20", 32'h20, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    check("mis_fault", {31'h0, fault}, 32'h1);
    check("mis_faddr", fault_addr, 32'h22);
    access("lhmis", 32'h31, 32'h0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0);
    check("first_wins", fault_addr, 32'h22);
    access("clr", 32'h0, 32'h0, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0);
    check("clr_fault", {31'h0, fault}, 32'h0);
    check("clr_faddr", fault_addr, 32'h0);

    access("rngclr", 32'(4 * DEPTH), 32'h0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0);
    check("clr_prio", {31'h0, fault}, 32'h0);
    access("rng", 32'(4 * DEPTH), 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    check("rng_fault", {31'h0, fault}, 32'h1);
    check("rng_faddr", fault_addr, 32'h400);
    access("clr2", 32'h0, 32'h0, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0);

    // Store lost to a reset pulse that straddles the edge.
    a = 32'h8; wd = 32'h12345678; we = 1'b1; mode = 3'd2; clr_fault = 1'b0;
    #6;
    reset = 1'b0;
    ref_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    we = 1'b0;
    access("rstlw8", 32'h8, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    access("rstlw10", 32'h10, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);

    for (int it = 0; it < 400; it++) begin
      pick = int'($urandom_range(0, 15));
      ra = 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if (pick == 0) ra = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      if (pick == 1) ra = 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 15));
      case (pick)
        0:       rm = 3'd3;
        1:       rm = 3'd6 + 3'($urandom_range(0, 1));
        default: rm = 3'($urandom_range(0, 2)) + (($urandom_range(0, 1) == 1 && pick > 8) ? 3'd4 : 3'd0);
      endcase
      if (rm == 3'd6 + 3'd0 && pick > 8) rm = 3'd2;
      access("rnd", ra, $urandom, 1'($urandom_range(0, 1)), rm,
             1'($urandom_range(0, 9) == 0), 1'b0, 32'h0);
    end
    access("rnd_clr", 32'h0, 32'h0, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      ra = 32'(4 * $urandom_range(0, DEPTH - 1));
      access("rnd_lw", ra, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0);
    end

`ifdef DMEM_MMIO_CYCLE_EN
    access("cnt_sw", MMIO, 32'h100, 1'b1, 3'd2, 1'b0, 1'b0, 32'h0);
    access("cnt_1", MMIO, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h101);
    access("cnt_2", MMIO, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h102);
    access("cnt_swmax", MMIO, 32'hFFFFFFFF, 1'b1, 3'd2, 1'b0, 1'b0, 32'h0);
    access("cnt_wrap", MMIO, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    access("cnt_lb", MMIO, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0);
    check("cnt_lb_fault", {31'h0, fault}, 32'h1);
    check("cnt_lb_faddr", fault_addr, MMIO);
`else
    access("nommio", MMIO, 32'h0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h0);
    check("nommio_fault", {31'h0, fault}, 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
